// File: rtl/truth_sweep_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_sweep_pkg : shared state encoding and constants for the sweeper
// Revision 1.0
// ---------------------------------------------------------------------------
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Implication a -> b (~a | b), indexed by stim = {a,b}
    localparam logic [3:0] IMPL_EXPECTED = 4'b1011;

    localparam int DEFAULT_N_IN = 2;

    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

    localparam int NUM_VEC = num_vec(DEFAULT_N_IN);

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_hold_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hold_timer : loadable down-counter, tc while enabled and count reaches zero
// Revision 1.0
// ---------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = en && (count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_table_sweeper : drives every input vector to a gate, holds, samples
// and compares against an expected truth table.  Revision 1.0
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int                        N_IN        = 2,
    parameter int                        HOLD_CYCLES = 10,
    parameter logic [(2**N_IN)-1:0]      EXPECTED    = IMPL_EXPECTED
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            sample_valid,
    output logic            sample_value
);

    localparam int              VECS     = num_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(VECS - 1);

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] index;
    logic            accept;
    logic            last;
    logic            mismatch;
    logic [N_IN:0]   err_next;
    logic            hold_load;
    logic            hold_tc;

    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign last     = (index == LAST_IDX);
    assign mismatch = (dut_out != EXPECTED[index]);
    assign err_next = err_count + {{N_IN{1'b0}}, mismatch};
    assign stim     = index;

    // Reload on sweep start and on every vector advance
    assign hold_load = accept || ((state == ST_SAMPLE) && !last);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .en    (state == ST_DRIVE),
        .tc    (hold_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)   state_next = ST_DRIVE;
            ST_DRIVE:         if (hold_tc) state_next = ST_SAMPLE;
            ST_SAMPLE:        state_next = last ? ST_DONE : ST_DRIVE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            sample_valid <= 1'b0;
            sample_value <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (accept) begin
                index     <= '0;
                err_count <= '0;
                done      <= 1'b0;
                pass      <= 1'b0;
                busy      <= 1'b1;
            end else if (state == ST_SAMPLE) begin
                sample_value <= dut_out;
                sample_valid <= 1'b1;
                err_count    <= err_next;
                if (last) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_next == '0);
                end else begin
                    index <= index + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper : vector-table and scoreboard bench for the sweeper
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dut_out;
    logic [1:0] stim;
    logic       busy, done, pass, sample_valid, sample_value;
    logic [2:0] err_count;

    int tests = 0;
    int fails = 0;
    int n_samples = 0;
    int mode = 0;       // 0: correct ~a|b, 1: stuck at 0, 2: a & ~b
    bit exp_q[$];

    always #5 clk = ~clk;

    truth_table_sweeper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dut_out      (dut_out),
        .stim         (stim),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .sample_valid (sample_valid),
        .sample_value (sample_value)
    );

    function automatic bit model(input int m, input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        case (m)
            0:       return ~a | b;
            1:       return 1'b0;
            default: return a & ~b;
        endcase
    endfunction

    assign dut_out = model(mode, stim);

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard: every sample pulse pops the value predicted at sweep start
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            n_samples++;
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                check("sample_value", int'(sample_value), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stim"}, int'(stim), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"},  int'(err_count), 0);
        check({tag, "_sval"}, int'(sample_value), 0);
    endtask

    task automatic run_sweep(input int m, input int exp_err, input bit exp_pass,
                             input bit repulse, input int rst_at);
        int  done_k;
        int  seq_bad;
        int  base_samples;
        logic [1:0] exp_stim;
        @(negedge clk);
        mode = m;
        for (int v = 0; v < 4; v++) exp_q.push_back(model(m, 2'(v)));
        base_samples = n_samples;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_done_clr", int'(done), 0);
        check("start_pass_clr", int'(pass), 0);
        check("start_err_clr", int'(err_count), 0);
        done_k  = -1;
        seq_bad = 0;
        for (int k = 1; k <= 60; k++) begin
            start = repulse && (k == 5 || k == 30);
            @(posedge clk);
            if (k == rst_at) begin
                #1 rst_n = 1'b0;
                #1 check_idle_outputs("async_rst");
                check("async_rst_sv", int'(sample_valid), 0);
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                repeat (3) @(negedge clk);
                check_idle_outputs("post_rst");
                return;
            end
            @(negedge clk);
            if (k <= 44) begin
                exp_stim = (k < 44) ? 2'(k / 11) : 2'd3;
                if (stim !== exp_stim) seq_bad++;
                if (busy !== (k < 44)) seq_bad++;
                if (done !== (k == 44)) seq_bad++;
            end
            if (done && done_k < 0) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        #1;
        check("stim_busy_seq_errors", seq_bad, 0);
        check("done_cycle", done_k, 44);
        check("err_count", int'(err_count), exp_err);
        check("pass", int'(pass), int'(exp_pass));
        check("sample_pulses", n_samples - base_samples, 4);
        check("scoreboard_left", exp_q.size(), 0);
    endtask

    typedef struct {
        int mode;
        int exp_err;
        bit exp_pass;
        bit repulse;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 0, 1'b1, 1'b0};   // correct gate
        vecs[1] = '{1, 3, 1'b0, 1'b0};   // stuck at 0
        vecs[2] = '{2, 4, 1'b0, 1'b0};   // inverted function
        vecs[3] = '{0, 0, 1'b1, 1'b1};   // start re-pulsed mid sweep
        vecs[4] = '{1, 3, 1'b0, 1'b0};   // faulty, leaves block in DONE
        vecs[5] = '{0, 0, 1'b1, 1'b0};   // restart from DONE with correct gate

        // Reset only: nothing moves, no sample pulses
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_no_samples", n_samples, 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i].mode, vecs[i].exp_err, vecs[i].exp_pass, vecs[i].repulse, 0);
        end

        // Done holds with start low
        repeat (5) @(negedge clk);
        check("done_held", int'(done), 1);
        check("pass_held", int'(pass), 1);

        // Reset mid vector 01, then a clean full sweep
        run_sweep(0, 0, 1'b1, 1'b0, 20);
        run_sweep(0, 0, 1'b1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
